// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        S_RELEASED  = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } btn_state_t;

    // Channel index of each button in the btn_* vectors.
    localparam int unsigned BTN_INCR = 0;
    localparam int unsigned BTN_DECR = 1;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and press-pulse generation.
// Auto-repeat while held is built only when BTN_CONDITIONER_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100,
    parameter int unsigned REPEAT_DELAY    = 5000,
    parameter int unsigned REPEAT_RATE     = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_busy
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_RATE < 2 || REPEAT_DELAY < 1)
    begin : g_param_err
        $error("btn_debounce_ch: illegal DEBOUNCE_CYCLES, REPEAT_DELAY or REPEAT_RATE");
    end

    logic            sync1_q, sync2_q;
    btn_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic            busy_q, busy_d;
    logic            accept;
    logic            rep_pulse;

    // Debounce FSM next state; each channel needs DEBOUNCE_CYCLES equal samples to switch level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_RELEASED: begin
                if (sync2_q) begin
                    cnt_d   = CntW'(1);
                    state_d = S_PRESS_CHK;
                end
            end
            S_PRESS_CHK: begin
                if (!sync2_q) begin
                    cnt_d   = '0;
                    state_d = S_RELEASED;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_HELD: begin
                if (!sync2_q) begin
                    cnt_d   = CntW'(1);
                    state_d = S_REL_CHK;
                end
            end
            S_REL_CHK: begin
                if (sync2_q) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = S_RELEASED;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_RELEASED;
            end
        endcase
    end

`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned     RepMax    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                         : REPEAT_RATE;
    localparam int unsigned     RepW      = $clog2(RepMax);
    localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

    logic [RepW-1:0] rcnt_q, rcnt_d;
    logic            rfirst_q, rfirst_d;  // still waiting for the first repeat after a press
    logic            rep_hit;

    // Repeat timer: counts through hold and release-check, fires only while firmly held.
    always_comb begin
        rcnt_d    = rcnt_q;
        rfirst_d  = rfirst_q;
        rep_pulse = 1'b0;
        rep_hit   = (rcnt_q == (rfirst_q ? DelayLast : RateLast));
        if (state_d == S_RELEASED || accept) begin
            rcnt_d   = '0;
            rfirst_d = 1'b1;
        end else if (state_q == S_HELD || state_q == S_REL_CHK) begin
            if (rep_hit) begin
                rcnt_d    = '0;
                rfirst_d  = 1'b0;
                rep_pulse = (state_q == S_HELD) && (state_d == S_HELD);
            end else begin
                rcnt_d = rcnt_q + RepW'(1);
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    // Output next values are decoded from the next state so outputs change with the state.
    always_comb begin
        level_d = (state_d == S_HELD) || (state_d == S_REL_CHK);
        busy_d  = (state_d == S_PRESS_CHK) || (state_d == S_REL_CHK);
        pulse_d = accept || rep_pulse;
    end

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign btn_busy  = busy_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounce channels feeding the PWM incr/decr inputs.
// Optional auto-repeat is enabled by defining BTN_CONDITIONER_AUTO_REPEAT_EN.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100,
    parameter int unsigned REPEAT_DELAY    = 5000,
    parameter int unsigned REPEAT_RATE     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_busy
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i]),
            .btn_busy (btn_busy[i])
        );
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage for the PWM duty controller: synchronises, debounces and edge-detects the raw increment/decrement push-buttons.
- Emits clean single-cycle press pulses, plus optional auto-repeat pulses while a button is held.
- Sits between the chip input pins and the PWM block's incr/decr controls.
- The PWM block consumes one pulse as exactly one duty step.

Parameters:
- N_BTN, 2: number of independent button channels (bit 0 = incr, bit 1 = decr).
- DEBOUNCE_CYCLES, 100: consecutive stable samples required to accept a level change; legal range 2..65535.
- REPEAT_DELAY, 5000: hold cycles after the accepted press before the first repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_RATE, 1000: cycles between subsequent repeat pulses (AUTO_REPEAT_EN only); must be >= 2.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous, bouncy button levels; 1 = pressed.
- btn_level  output  N_BTN  debounced level per channel.
- btn_pulse  output  N_BTN  one-cycle strobe per accepted press or repeat.
- btn_busy  output  N_BTN  high while a channel is counting a candidate level change.

Behaviour:
- Reset: synchronous, active-high; sampled on the rising edge of clk.
  - While reset is high, all outputs are 0, counters are 0, synchroniser flops are 0, and every channel is in S_RELEASED.
  - Reset mid-count or mid-hold aborts the operation; no pulse is emitted on the reset cycle or on the cycle after it.
- Synchroniser: two flops per channel. sync = btn_raw delayed 2 cycles. Only sync feeds the FSM.
- Per-channel FSM states:
  - S_RELEASED: btn_level = 0. If sync = 1, load cnt = 1 and go to S_PRESS_CHK.
  - S_PRESS_CHK: btn_busy = 1.
    - If sync = 0, go to S_RELEASED with cnt = 0 (bounce rejected, no pulse).
    - If cnt = DEBOUNCE_CYCLES-1, go to S_HELD; btn_level becomes 1 and btn_pulse is 1 for exactly that transition cycle.
    - Otherwise cnt increments.
  - S_HELD: btn_level = 1.
    - If sync = 0, load cnt = 1 and go to S_REL_CHK.
    - Auto-repeat counting in this state is described under Optional Feature.
  - S_REL_CHK: btn_busy = 1, btn_level stays 1.
    - If sync = 1, return to S_HELD; the repeat counter is preserved, not restarted.
    - If cnt = DEBOUNCE_CYCLES-1, go to S_RELEASED and btn_level becomes 0. No pulse is emitted on release.
- Latency: a clean press asserts btn_pulse 2 (sync) + DEBOUNCE_CYCLES cycles after the btn_raw rising edge.
  - With DEBOUNCE_CYCLES = 4, a raw rise at cycle 0 gives btn_pulse at cycle 6.
- Counters:
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES).
  - Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)).
  - Counters saturate rather than wrap; overflow cannot occur.
- Channels are fully independent. Simultaneous presses of incr and decr produce pulses on both bits in the same cycle; arbitration belongs to the PWM block.
- btn_pulse is registered. It is never high for two consecutive cycles on the same channel.

Optional Feature:
- Macro: BTN_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - S_HELD runs rcnt from the accepted press.
  - When rcnt reaches REPEAT_DELAY, emit a pulse and reload for REPEAT_RATE.
  - After that, emit one pulse every REPEAT_RATE cycles while the channel stays in S_HELD or S_REL_CHK.
  - Repeat pulses are suppressed while in S_REL_CHK; the counter still runs.
  - rcnt is cleared on entry to S_RELEASED.
- Undefined:
  - The repeat counter and its logic are absent.
  - REPEAT_DELAY and REPEAT_RATE are ignored.
  - Exactly one pulse is emitted per accepted press.

Decomposition:
- Package btn_conditioner_pkg holds:
  - the state enum btn_state_t (S_RELEASED, S_PRESS_CHK, S_HELD, S_REL_CHK), 2 bits;
  - the localparams BTN_INCR = 0 and BTN_DECR = 1.
- Sub-module btn_debounce_ch: one channel containing the synchroniser, FSM and counters.
  - btn_conditioner instantiates it N_BTN times in a generate loop.
  - It adds no top-level logic beyond wiring.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4): hold btn_raw[0] high for 20 cycles.
  - Expect exactly one btn_pulse[0], 6 cycles after the rise.
  - btn_level[0] is 1 from that cycle on; btn_pulse[1] stays 0 throughout.
- Bounce rejection: toggle btn_raw[1] high 2 cycles / low 1 cycle, repeated 5 times, then hold low.
  - Expect no btn_pulse[1].
  - btn_busy[1] pulses; btn_level[1] stays 0.
- Release glitch: from S_HELD, drop btn_raw[0] for 2 cycles, then restore it.
  - Expect btn_level[0] to stay 1 and no new pulse.
  - A low of 4+ cycles must then clear btn_level[0] with no pulse on release.
- Simultaneous press: raise both btn_raw bits on the same cycle.
  - Expect btn_pulse = 2'b11 on a single cycle, 6 cycles later.
- Reset mid-operation: assert reset at cnt = 2 of S_PRESS_CHK.
  - Expect all outputs 0 on the next edge.
  - After reset is released with the button still held, expect a fresh full debounce: pulse 2+4 cycles after the reset release.
- Auto-repeat (macro defined; REPEAT_DELAY=10, REPEAT_RATE=3): hold the button 30 cycles past acceptance.
  - Expect pulses at acceptance, +10, +13, +16, ... +28.
  - With the macro undefined, expect the pulse at acceptance only.
